// File: rtl/serial_word_deserializer_pkg.sv
// Shared types and helpers for the serial word deserializer.
package serial_pkg;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

  function automatic int beats(input int width, input int lanes);
    return width / lanes;
  endfunction

  // A single-beat word still needs a 1-bit counter so the slice stays legal.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_word_deserializer_if.sv
// Handshake bundle between the serial load path and the deserializer.
interface serial_word_deserializer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 1
);
  logic             clr;
  logic             en;
  logic [LANES-1:0] data_in;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;
  logic             busy;
  logic             overflow;

  modport master (output clr, en, data_in, ready, input data, valid, busy, overflow);
  modport slave  (input clr, en, data_in, ready, output data, valid, busy, overflow);
endinterface

// File: rtl/serial_word_deserializer_shifter.sv
// Input side: gathers LANES bits per beat into a word and flags the completing beat.
module serial_lane_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [LANES-1:0] i_data_in,
  output logic             o_word_done,
  output logic [WIDTH-1:0] o_word,
  output logic             o_busy
);
  localparam int BEATS = beats(WIDTH, LANES);
  localparam int CW    = cnt_width(BEATS);

  logic [WIDTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_shifted;
  logic             w_last;

  // With one beat per word the shift register contributes nothing.
  generate
    if (WIDTH == LANES) begin : g_single
      assign w_shifted = i_data_in;
    end else if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sr[WIDTH-LANES-1:0], i_data_in};
    end else begin : g_lsb
      assign w_shifted = {i_data_in, r_sr[WIDTH-1:LANES]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(BEATS - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_clr) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_sr  <= '0;
        r_cnt <= '0;
      end else begin
        r_sr  <= w_shifted;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_word_done = i_en & ~i_clr & w_last;
  assign o_word      = w_shifted;
  assign o_busy      = (r_cnt != '0);
endmodule

// File: rtl/serial_word_deserializer.sv
// Serial-to-parallel loader: lane shifter feeding a one-entry VALID/READY output stage.
module serial_word_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                      i_clk,
  input logic                      i_rst_n,
  serial_word_deserializer_if.slave bus
);
  generate
    if ((WIDTH < 1) || (LANES < 1) || (WIDTH % LANES != 0)) begin : g_param_check
      $error("serial_word_deserializer: WIDTH must be >= 1 and a multiple of LANES");
    end
  endgenerate

  logic             w_word_done;
  logic [WIDTH-1:0] w_word;
  logic             w_busy;

  out_state_t       r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic             r_overflow, w_overflow_next;

  serial_lane_shifter #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clr       (bus.clr),
    .i_en        (bus.en),
    .i_data_in   (bus.data_in),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_busy      (w_busy)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= OUT_EMPTY;
      r_data     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_data     <= w_data_next;
      r_overflow <= w_overflow_next;
    end
  end

  // A completion while the held word is not being taken loses the new word.
  always_comb begin
    w_state_next    = r_state;
    w_data_next     = r_data;
    w_overflow_next = r_overflow;
    case (r_state)
      OUT_EMPTY: begin
        if (w_word_done) begin
          w_state_next = OUT_FULL;
          w_data_next  = w_word;
        end
      end
      OUT_FULL: begin
        if (w_word_done && bus.ready) begin
          w_data_next = w_word;
        end else if (w_word_done) begin
          w_overflow_next = 1'b1;
        end else if (bus.ready) begin
          w_state_next = OUT_EMPTY;
        end
      end
      default: w_state_next = OUT_EMPTY;
    endcase
    if (bus.clr) begin
      w_overflow_next = 1'b0;
    end
  end

  assign bus.data     = r_data;
  assign bus.valid    = (r_state == OUT_FULL);
  assign bus.busy     = w_busy;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// Directed bench for several deserializer configurations, checked against a beat-queue model.
module tb_serial_word_deserializer;
  localparam int NI = 5;
  localparam int W_T [NI] = '{3, 8, 4, 4, 8};
  localparam int L_T [NI] = '{1, 2, 4, 1, 1};
  localparam int M_T [NI] = '{1, 0, 1, 1, 1};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  serial_word_deserializer_if #(.WIDTH(3), .LANES(1)) if0 ();
  serial_word_deserializer_if #(.WIDTH(8), .LANES(2)) if1 ();
  serial_word_deserializer_if #(.WIDTH(4), .LANES(4)) if2 ();
  serial_word_deserializer_if #(.WIDTH(4), .LANES(1)) if3 ();
  serial_word_deserializer_if #(.WIDTH(8), .LANES(1)) if4 ();

  serial_word_deserializer #(.WIDTH(3), .LANES(1), .MSB_FIRST(1'b1)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(if0));
  serial_word_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b0)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
  serial_word_deserializer #(.WIDTH(4), .LANES(4), .MSB_FIRST(1'b1)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(if2));
  serial_word_deserializer #(.WIDTH(4), .LANES(1), .MSB_FIRST(1'b1)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(if3));
  serial_word_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u4 (.i_clk(clk), .i_rst_n(rst_n), .bus(if4));

  // Model: beats are queued, then the word is composed arithmetically from the queue.
  int          m_cnt   [NI];
  logic [31:0] m_bq    [NI][8];
  logic [31:0] m_data  [NI];
  bit          m_valid [NI];
  bit          m_ovf   [NI];

  function automatic void model_step(int i, bit clr, bit en, logic [31:0] din, bit ready);
    int          nb;
    logic [31:0] w;
    bit          done;
    nb   = W_T[i] / L_T[i];
    done = en && !clr && (m_cnt[i] == nb - 1);
    if (en && !clr) m_bq[i][m_cnt[i]] = din;
    if (done) begin
      w = 0;
      for (int k = 0; k < nb; k++)
        w |= m_bq[i][k] << (L_T[i] * ((M_T[i] != 0) ? (nb - 1 - k) : k));
      if (m_valid[i] && !ready) m_ovf[i] = 1'b1;
      else begin
        m_data[i]  = w;
        m_valid[i] = 1'b1;
      end
      m_cnt[i] = 0;
    end else begin
      if (m_valid[i] && ready) m_valid[i] = 1'b0;
      if (en && !clr) m_cnt[i]++;
    end
    if (clr) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_cnt[i] = 0; m_data[i] = 0; m_valid[i] = 0; m_ovf[i] = 0;
      end
    end else begin
      model_step(0, if0.clr, if0.en, 32'(if0.data_in), if0.ready);
      model_step(1, if1.clr, if1.en, 32'(if1.data_in), if1.ready);
      model_step(2, if2.clr, if2.en, 32'(if2.data_in), if2.ready);
      model_step(3, if3.clr, if3.en, 32'(if3.data_in), if3.ready);
      model_step(4, if4.clr, if4.en, 32'(if4.data_in), if4.ready);
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int i, logic [31:0] d, logic v, logic b, logic o);
    chk($sformatf("m%0d.data", i), d, m_data[i]);
    chk($sformatf("m%0d.valid", i), 32'(v), 32'(m_valid[i]));
    chk($sformatf("m%0d.busy", i), 32'(b), 32'(m_cnt[i] != 0));
    chk($sformatf("m%0d.overflow", i), 32'(o), 32'(m_ovf[i]));
  endtask

  always @(negedge clk) begin
    cmp(0, 32'(if0.data), if0.valid, if0.busy, if0.overflow);
    cmp(1, 32'(if1.data), if1.valid, if1.busy, if1.overflow);
    cmp(2, 32'(if2.data), if2.valid, if2.busy, if2.overflow);
    cmp(3, 32'(if3.data), if3.valid, if3.busy, if3.overflow);
    cmp(4, 32'(if4.data), if4.valid, if4.busy, if4.overflow);
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  logic [1:0] t3_beats [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  logic [3:0] t4_words [3] = '{4'hA, 4'hB, 4'hC};
  logic [3:0] pat;
  bit         en_pat [20];
  bit         tmp_b, prev_v;
  int         j, rises;
  logic [31:0] exp_w;

  initial begin
    if0.clr = 0; if0.en = 0; if0.data_in = 0; if0.ready = 0;
    if1.clr = 0; if1.en = 0; if1.data_in = 0; if1.ready = 0;
    if2.clr = 0; if2.en = 0; if2.data_in = 0; if2.ready = 0;
    if3.clr = 0; if3.en = 0; if3.data_in = 0; if3.ready = 0;
    if4.clr = 0; if4.en = 0; if4.data_in = 0; if4.ready = 0;
    tick(2);
    chk("reset_valid", 32'(if4.valid), 0);
    rst_n = 1'b1;
    tick(1);

    // Legacy 3-bit MSB-first word
    if0.en = 1;
    if0.data_in = 1; tick(1);
    if0.data_in = 0; tick(1);
    if0.data_in = 1; tick(1);
    if0.en = 0;
    chk("t2_data", 32'(if0.data), 32'h5);
    chk("t2_valid", 32'(if0.valid), 1);
    tick(3);
    chk("t2_stall_data", 32'(if0.data), 32'h5);
    chk("t2_stall_valid", 32'(if0.valid), 1);

    // Two lanes, LSB-first
    if1.en = 1;
    for (int k = 0; k < 4; k++) begin
      if1.data_in = t3_beats[k];
      tick(1);
      if (k < 3) chk($sformatf("t3_busy%0d", k), 32'(if1.busy), 1);
    end
    if1.en = 0;
    chk("t3_data", 32'(if1.data), 32'h39);
    chk("t3_valid", 32'(if1.valid), 1);
    chk("t3_busy_end", 32'(if1.busy), 0);

    // Back-to-back words with READY high, then a drop
    if2.ready = 1; if2.en = 1;
    for (int k = 0; k < 3; k++) begin
      if2.data_in = t4_words[k];
      tick(1);
      chk($sformatf("t4_data%0d", k), 32'(if2.data), 32'(t4_words[k]));
      chk($sformatf("t4_valid%0d", k), 32'(if2.valid), 1);
    end
    if2.ready = 0; if2.data_in = 4'hD;
    tick(1);
    if2.en = 0;
    chk("t4_drop_data", 32'(if2.data), 32'hC);
    chk("t4_overflow", 32'(if2.overflow), 1);
    if2.ready = 1;
    tick(1);
    if2.ready = 0;
    chk("t4_consumed_valid", 32'(if2.valid), 0);
    chk("t4_kept_data", 32'(if2.data), 32'hC);

    // CLR mid-word, also clearing an overflow
    if3.en = 1;
    pat = 4'b1001;
    for (int k = 0; k < 4; k++) begin if3.data_in = pat[3-k]; tick(1); end
    pat = 4'b0110;
    for (int k = 0; k < 4; k++) begin if3.data_in = pat[3-k]; tick(1); end
    chk("t5_ovf_set", 32'(if3.overflow), 1);
    chk("t5_first_word", 32'(if3.data), 32'h9);
    if3.data_in = 1; tick(2);
    chk("t5_busy_pre", 32'(if3.busy), 1);
    if3.clr = 1; if3.ready = 1;
    tick(1);
    if3.clr = 0; if3.ready = 0;
    chk("t5_busy_clr", 32'(if3.busy), 0);
    chk("t5_ovf_clr", 32'(if3.overflow), 0);
    chk("t5_valid_taken", 32'(if3.valid), 0);
    pat = 4'b1101;
    for (int k = 0; k < 4; k++) begin if3.data_in = pat[3-k]; tick(1); end
    if3.en = 0;
    chk("t5_data", 32'(if3.data), 32'hD);
    chk("t5_valid", 32'(if3.valid), 1);

    // Async reset mid-word
    if4.en = 1; if4.data_in = 1;
    tick(2);
    if4.en = 0;
    chk("t1_busy_pre", 32'(if4.busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_data", 32'(if4.data), 0);
    chk("t1_valid", 32'(if4.valid), 0);
    chk("t1_busy", 32'(if4.busy), 0);
    chk("t1_ovf", 32'(if2.overflow), 0);
    chk("t1_other_data", 32'(if0.data), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Random stalls: 8 beats spread over 20 cycles
    for (int k = 0; k < 20; k++) en_pat[k] = (k < 8);
    for (int k = 19; k > 0; k--) begin
      j = int'($urandom_range(k, 0));
      tmp_b = en_pat[k]; en_pat[k] = en_pat[j]; en_pat[j] = tmp_b;
    end
    exp_w = 0; rises = 0; prev_v = 0;
    for (int k = 0; k < 20; k++) begin
      if4.en = en_pat[k];
      if4.data_in = 1'($urandom_range(1, 0));
      if (en_pat[k]) exp_w = ((exp_w << 1) | 32'(if4.data_in)) & 32'hFF;
      tick(1);
      if (if4.valid && !prev_v) rises++;
      prev_v = if4.valid;
    end
    if4.en = 0;
    tick(1);
    chk("t6_words", 32'(rises), 1);
    chk("t6_data", 32'(if4.data), exp_w);
    chk("t6_valid", 32'(if4.valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
